mem_port_sequencer: RTL and testbench

//  Shares the single-ported data/instruction memory between instruction fetch (IF) and the

---
 rtl/mem_port_sequencer_if.sv | 49 ++++
 rtl/mem_port_sequencer.sv | 168 ++++++++++++++++
 tb/tb_mem_port_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_sequencer_if.sv
// ============================================================================
// Module   : mem_port_sequencer_if
// Purpose  : Fetch, load/store and memory-side signal bundle for the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_port_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              halted;
  logic              busy;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [31:0]       if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic              dm_byte;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_ready;
  logic [31:0]       dm_rdata;
  logic              dm_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Sequencer side
  modport slave (
    input  halted, if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, mem_rdata,
    output busy, if_ready, if_rdata, dm_ready, dm_rdata, dm_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Core datapath plus memory model side
  modport master (
    output halted, if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, mem_rdata,
    input  busy, if_ready, if_rdata, dm_ready, dm_rdata, dm_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_sequencer.sv
// ============================================================================
// Module   : mem_port_sequencer
// Purpose  : Arbitrates one single-ported memory between fetch and load/store,
//            with sign-extended byte loads and read-modify-write byte stores.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_sequencer #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_b,
  mem_port_sequencer_if.slave bus
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DRD     = 3'd2,
    DWR     = 3'd3,
    RMW_RD  = 3'd4,
    RMW_WR  = 3'd5,
    DONE_IF = 3'd6,
    DONE_DM = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              byte_q, byte_d;
  logic [1:0]        lane_q, lane_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;

  logic              access;
  logic              last;
  logic [7:0]        rd_byte;
  logic [4:0]        lane_sh;
  logic [31:0]       merged;

  assign access  = (state_q == FETCH) || (state_q == DRD) || (state_q == DWR) ||
                   (state_q == RMW_RD) || (state_q == RMW_WR);
  assign last    = (cnt_q == CNT_LAST);
  assign lane_sh = {lane_q, 3'b000};

  always_comb begin
    rd_byte = bus.mem_rdata[7:0];
    case (lane_q)
      2'd1:    rd_byte = bus.mem_rdata[15:8];
      2'd2:    rd_byte = bus.mem_rdata[23:16];
      2'd3:    rd_byte = bus.mem_rdata[31:24];
      default: rd_byte = bus.mem_rdata[7:0];
    endcase
  end

  // Only the addressed lane is replaced; the rest of the word is written back as read.
  assign merged = (bus.mem_rdata & ~(32'h0000_00FF << lane_sh)) |
                  ({24'd0, mem_wdata_q[7:0]} << lane_sh);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    lane_d      = lane_q;
    err_d       = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      IDLE: begin
        // A requester whose err pulse is showing is still holding its stale request.
        if (!bus.halted) begin
          if (bus.dm_req && !err_q) begin
            if (!bus.dm_byte && (bus.dm_addr[1:0] != 2'b00)) begin
              err_d = 1'b1;
            end else begin
              cnt_d       = '0;
              byte_d      = bus.dm_byte;
              lane_d      = bus.dm_addr[1:0];
              mem_addr_d  = bus.dm_addr & WORD_MASK;
              mem_wdata_d = bus.dm_wdata;
              if (!bus.dm_we)       state_d = DRD;
              else if (bus.dm_byte) state_d = RMW_RD;
              else                  state_d = DWR;
            end
          end else if (bus.if_req) begin
            cnt_d      = '0;
            mem_addr_d = bus.if_addr & WORD_MASK;
            state_d    = FETCH;
          end
        end
      end

      FETCH, DRD, DWR, RMW_RD, RMW_WR: begin
        cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        if (last) begin
          case (state_q)
            FETCH: begin
              if_rdata_d = bus.mem_rdata;
              state_d    = DONE_IF;
            end
            DRD: begin
              dm_rdata_d = byte_q ? {{24{rd_byte[7]}}, rd_byte} : bus.mem_rdata;
              state_d    = DONE_DM;
            end
            RMW_RD: begin
              mem_wdata_d = merged;
              state_d     = RMW_WR;
            end
            default: state_d = DONE_DM;
          endcase
        end
      end

      DONE_IF, DONE_DM: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      byte_q      <= 1'b0;
      lane_q      <= 2'b00;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      lane_q      <= lane_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.if_ready  = (state_q == DONE_IF);
  assign bus.dm_ready  = (state_q == DONE_DM);
  assign bus.dm_err    = err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_en    = access && (cnt_q == '0);
  assign bus.mem_we    = (state_q == DWR) || (state_q == RMW_WR);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_sequencer.sv
// ============================================================================
// Module   : tb_mem_port_sequencer
// Purpose  : Self-checking bench with a local memory model and result queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_sequencer;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  mem_port_sequencer_if #(.ADDR_W(32)) mif();

  mem_port_sequencer #(.MEM_LATENCY(2), .ADDR_W(32)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (mif)
  );

  // Memory model: 1 KiB, write on the strobe edge, combinational read.
  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [31:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          en_cnt = 0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr[9:2]] <= pl_data;
    else if (mif.mem_en && mif.mem_we) mem[mif.mem_addr[9:2]] <= mif.mem_wdata;
    if (mif.mem_en === 1'b1) en_cnt <= en_cnt + 1;
  end
  assign mif.mem_rdata = mem[mif.mem_addr[9:2]];

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_dm(input logic we, input logic bt, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic rdy, output logic err, output logic [31:0] rd);
    mif.dm_req = 1'b1; mif.dm_we = we; mif.dm_byte = bt; mif.dm_addr = a; mif.dm_wdata = wd;
    lat = 0; rdy = 1'b0; err = 1'b0; rd = '0;
    while (!rdy && !err && lat < 20) begin
      @(negedge clk);
      lat++;
      rdy = mif.dm_ready; err = mif.dm_err; rd = mif.dm_rdata;
    end
    mif.dm_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({mif.busy, mif.if_ready, mif.dm_ready, mif.dm_err, mif.mem_en, mif.mem_we} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000",
        {mif.busy, mif.if_ready, mif.dm_ready, mif.dm_err, mif.mem_en, mif.mem_we});
    end
    checks++;
    if ({mif.mem_addr, mif.mem_wdata, mif.if_rdata, mif.dm_rdata} !== 128'b0) begin
      errors++; $display("FAIL reset_data: got %h expected 0",
        {mif.mem_addr, mif.mem_wdata, mif.if_rdata, mif.dm_rdata});
    end
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  task automatic test_fetch();
    int lat; int e0; logic [31:0] exp;
    preload(32'h40, 32'h2008_0005);
    exp_q.push_back(32'h2008_0005);
    e0 = en_cnt;
    mif.if_addr = 32'h40; mif.if_req = 1'b1;
    lat = 0;
    while (mif.if_ready !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    mif.if_req = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (lat != 3) begin errors++; $display("FAIL fetch_latency: got %0d expected 3", lat); end
    checks++;
    if (mif.if_rdata !== exp) begin errors++; $display("FAIL fetch_data: got %h expected %h", mif.if_rdata, exp); end
    checks++;
    if (en_cnt - e0 != 1) begin errors++; $display("FAIL fetch_mem_en: got %0d expected 1", en_cnt - e0); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int cyc; int dm_at; int if_at; int e0; logic [31:0] exp;
    preload(32'h100, 32'h80FF_1234);
    exp_q.push_back(32'h80FF_1234);
    exp_q.push_back(32'h2008_0005);
    e0 = en_cnt; dm_at = 0; if_at = 0; cyc = 0;
    mif.dm_we = 1'b0; mif.dm_byte = 1'b0; mif.dm_addr = 32'h100; mif.dm_req = 1'b1;
    mif.if_addr = 32'h40; mif.if_req = 1'b1;
    while ((dm_at == 0 || if_at == 0) && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (mif.dm_ready === 1'b1) begin
        dm_at = cyc; mif.dm_req = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (mif.dm_rdata !== exp) begin errors++; $display("FAIL cont_dm_data: got %h expected %h", mif.dm_rdata, exp); end
      end
      if (mif.if_ready === 1'b1) begin
        if_at = cyc; mif.if_req = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (mif.if_rdata !== exp) begin errors++; $display("FAIL cont_if_data: got %h expected %h", mif.if_rdata, exp); end
      end
    end
    checks++;
    if (dm_at != 3 || if_at != 7) begin
      errors++; $display("FAIL cont_order: got dm@%0d if@%0d expected dm@3 if@7", dm_at, if_at);
    end
    checks++;
    if (en_cnt - e0 != 2) begin errors++; $display("FAIL cont_mem_en: got %0d expected 2", en_cnt - e0); end
    mif.dm_req = 1'b0; mif.if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lb();
    logic [31:0] addrs [3];
    logic [31:0] exps  [3];
    int lat; logic rdy; logic err; logic [31:0] rd; logic [31:0] exp;
    addrs = '{32'h103, 32'h101, 32'h100};
    exps  = '{32'hFFFF_FF80, 32'h0000_0012, 32'h0000_0034};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exps[i]);
      do_dm(1'b0, 1'b1, addrs[i], 32'h0, lat, rdy, err, rd);
      exp = exp_q.pop_front();
      checks++;
      if (!rdy || rd !== exp || lat != 3) begin
        errors++; $display("FAIL lb_%h: got %h lat %0d expected %h lat 3", addrs[i], rd, lat, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sb();
    int lat; int e0; logic rdy; logic err; logic [31:0] rd;
    preload(32'h200, 32'h1122_3344);
    e0 = en_cnt;
    do_dm(1'b1, 1'b1, 32'h201, 32'hDEAD_BEAB, lat, rdy, err, rd);
    checks++;
    if (!rdy || lat != 5) begin errors++; $display("FAIL sb_latency: got %0d expected 5", lat); end
    checks++;
    if (en_cnt - e0 != 2) begin errors++; $display("FAIL sb_mem_en: got %0d expected 2", en_cnt - e0); end
    checks++;
    if (mem[32'h200 >> 2] !== 32'h1122_AB44) begin
      errors++; $display("FAIL sb_lane1: got %h expected 1122ab44", mem[32'h200 >> 2]);
    end
    @(negedge clk);
    do_dm(1'b1, 1'b1, 32'h203, 32'h0000_0077, lat, rdy, err, rd);
    checks++;
    if (mem[32'h200 >> 2] !== 32'h7722_AB44) begin
      errors++; $display("FAIL sb_lane3: got %h expected 7722ab44", mem[32'h200 >> 2]);
    end
    @(negedge clk);
  endtask

  task automatic test_word_store();
    int lat; logic rdy; logic err; logic [31:0] rd; logic [31:0] exp;
    do_dm(1'b1, 1'b0, 32'h300, 32'hCAFE_F00D, lat, rdy, err, rd);
    checks++;
    if (!rdy || lat != 3) begin errors++; $display("FAIL sw_latency: got %0d expected 3", lat); end
    exp_q.push_back(32'hCAFE_F00D);
    @(negedge clk);
    do_dm(1'b0, 1'b0, 32'h300, 32'h0, lat, rdy, err, rd);
    exp = exp_q.pop_front();
    checks++;
    if (!rdy || rd !== exp) begin errors++; $display("FAIL sw_readback: got %h expected %h", rd, exp); end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    int lat; int e0; logic rdy; logic err; logic [31:0] rd; logic seen;
    e0 = en_cnt; seen = 1'b0;
    do_dm(1'b0, 1'b0, 32'h102, 32'h0, lat, rdy, err, rd);
    checks++;
    if (!err || rdy || lat != 1) begin
      errors++; $display("FAIL misalign_err: got err=%b rdy=%b lat %0d expected err=1 rdy=0 lat 1", err, rdy, lat);
    end
    do_dm(1'b1, 1'b0, 32'h301, 32'h5555_5555, lat, rdy, err, rd);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mif.dm_ready || mif.busy || mif.dm_err) seen = 1'b1;
    end
    checks++;
    if (!err || en_cnt - e0 != 0 || seen) begin
      errors++; $display("FAIL misalign_noaccess: got err=%b mem_en=%0d activity=%b expected 1 0 0", err, en_cnt - e0, seen);
    end
  endtask

  task automatic test_latch();
    int lat; logic [31:0] exp;
    exp_q.push_back(32'h80FF_1234);
    mif.dm_we = 1'b0; mif.dm_byte = 1'b0; mif.dm_addr = 32'h100; mif.dm_req = 1'b1;
    @(negedge clk);
    mif.dm_addr = 32'h40; mif.dm_byte = 1'b1; mif.dm_we = 1'b1;
    lat = 1;
    while (mif.dm_ready !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    mif.dm_req = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (mif.dm_rdata !== exp || lat != 3) begin
      errors++; $display("FAIL latch_inputs: got %h lat %0d expected %h lat 3", mif.dm_rdata, lat, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat; logic rdy; logic err; logic [31:0] rd; logic [31:0] exp;
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'hFFFF_FF80);
    do_dm(1'b0, 1'b1, 32'h102, 32'h0, lat, rdy, err, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL b2b_first: got %h expected %h", rd, exp); end
    do_dm(1'b0, 1'b1, 32'h103, 32'h0, lat, rdy, err, rd);
    exp = exp_q.pop_front();
    checks++;
    if (rd !== exp || lat != 4) begin
      errors++; $display("FAIL b2b_second: got %h lat %0d expected %h lat 4", rd, lat, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_halt();
    int e0; int lat; logic seen; logic [31:0] exp;
    e0 = en_cnt; seen = 1'b0;
    mif.halted = 1'b1; mif.if_addr = 32'h40; mif.if_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mif.busy !== 1'b0 || mif.if_ready !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || en_cnt - e0 != 0) begin
      errors++; $display("FAIL halt_block: got activity=%b mem_en=%0d expected 0 0", seen, en_cnt - e0);
    end
    exp_q.push_back(32'h2008_0005);
    mif.halted = 1'b0;
    lat = 0;
    while (mif.if_ready !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    mif.if_req = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (mif.if_rdata !== exp || lat != 3) begin
      errors++; $display("FAIL halt_release: got %h lat %0d expected %h lat 3", mif.if_rdata, lat, exp);
    end
    @(negedge clk);
    // Halt raised after the grant must not stall the access in flight.
    exp_q.push_back(32'h80FF_1234);
    mif.dm_we = 1'b0; mif.dm_byte = 1'b0; mif.dm_addr = 32'h100; mif.dm_req = 1'b1;
    @(negedge clk);
    mif.halted = 1'b1;
    lat = 1;
    while (mif.dm_ready !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    mif.dm_req = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (mif.dm_rdata !== exp || lat != 3) begin
      errors++; $display("FAIL halt_midaccess: got %h lat %0d expected %h lat 3", mif.dm_rdata, lat, exp);
    end
    @(negedge clk);
    mif.halted = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    logic seen;
    seen = 1'b0;
    mif.dm_we = 1'b1; mif.dm_byte = 1'b0; mif.dm_addr = 32'h304; mif.dm_wdata = 32'h1234_5678;
    mif.dm_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mif.busy !== 1'b1 || mif.mem_we !== 1'b1 || mif.mem_addr !== 32'h304) begin
      errors++; $display("FAIL rst_setup: got busy=%b we=%b addr=%h expected 1 1 00000304", mif.busy, mif.mem_we, mif.mem_addr);
    end
    #2;
    rst_b = 1'b1;
    mif.dm_req = 1'b0;
    #1;
    checks++;
    if ({mif.busy, mif.mem_en, mif.mem_we, mif.dm_ready, mif.mem_addr, mif.mem_wdata, mif.dm_rdata} !== 100'b0) begin
      errors++; $display("FAIL rst_async: got busy=%b addr=%h wdata=%h rdata=%h expected all 0",
        mif.busy, mif.mem_addr, mif.mem_wdata, mif.dm_rdata);
    end
    @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mif.dm_ready !== 1'b0 || mif.busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_no_ready: got activity=1 expected 0"); end
  endtask

  initial begin
    mif.halted = 1'b0; mif.if_req = 1'b0; mif.if_addr = '0;
    mif.dm_req = 1'b0; mif.dm_we = 1'b0; mif.dm_byte = 1'b0; mif.dm_addr = '0; mif.dm_wdata = '0;
    test_reset();
    test_fetch();
    test_contention();
    test_lb();
    test_sb();
    test_word_store();
    test_misaligned();
    test_latch();
    test_back_to_back();
    test_halt();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
